// File: rtl/serial_add_sched.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sched
// Description : Round-robin scheduler that arbitrates two requesters onto a
//               shared external bit-serial adder. Operands are shifted out
//               LSB first, the returned sum bits are collected into a result
//               register, and the final carry becomes the carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             sa_a,
   output logic             sa_b,
   output logic             sa_clr,
   input  logic             sa_s
);

   // Counter must reach WIDTH: the extra ADD cycle harvests the final carry.
   localparam int                c_cnt_w    = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_ADD   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_sa;
   logic [WIDTH-1:0]     r_sb;
   logic [WIDTH:0]       r_res;
   logic [WIDTH:0]       w_res_next;
   logic [c_cnt_w-1:0]   r_cnt;
   logic                 r_last_id;
   logic                 r_owner;
   logic                 r_sa_clr;
   logic                 w_pick1;
   logic                 w_last_add;

   // With both requesting, requester 1 wins only if 0 won last time.
   assign w_pick1    = req1 & (~req0 | ~r_last_id);
   assign w_last_add = (r_cnt == c_last_cnt);
   assign w_res_next = {sa_s, r_res[WIDTH:1]};
   assign sa_clr     = r_sa_clr;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode plus grant, status and serial-operand outputs.
   always_comb begin
      w_next = r_state;
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      busy   = 1'b1;
      done   = 1'b0;
      sa_a   = 1'b0;
      sa_b   = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (req0 | req1) begin
               gnt0   = ~w_pick1;
               gnt1   = w_pick1;
               w_next = S_CLEAR;
            end
         end
         S_CLEAR: begin
            w_next = S_ADD;
         end
         S_ADD: begin
            // Zero operands on the last cycle so sa_s reflects the carry alone.
            if (!w_last_add) begin
               sa_a = r_sa[0];
               sa_b = r_sb[0];
            end
            if (w_last_add) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, serial shifting, result collection and
   // the held result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sa      <= '0;
         r_sb      <= '0;
         r_res     <= '0;
         r_cnt     <= '0;
         r_last_id <= 1'b1;
         r_owner   <= 1'b0;
         r_sa_clr  <= 1'b1;
         sum       <= '0;
         cout      <= 1'b0;
         done_id   <= 1'b0;
      end else begin
         // Adder carry is held cleared everywhere except during ADD.
         r_sa_clr <= (w_next != S_ADD);
         case (r_state)
            S_IDLE: begin
               if (gnt0 | gnt1) begin
                  r_sa      <= gnt1 ? a1 : a0;
                  r_sb      <= gnt1 ? b1 : b0;
                  r_owner   <= gnt1;
                  r_last_id <= gnt1;
               end
            end
            S_CLEAR: begin
               r_cnt <= '0;
            end
            S_ADD: begin
               r_res <= w_res_next;
               r_sa  <= r_sa >> 1;
               r_sb  <= r_sb >> 1;
               r_cnt <= r_cnt + 1'b1;
               // The last sum bit arrives on this same edge, so use w_res_next.
               if (w_last_add) begin
                  sum     <= w_res_next[WIDTH-1:0];
                  cout    <= w_res_next[WIDTH];
                  done_id <= r_owner;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_sched
// Description : Directed and random testbench for serial_add_sched with a
//               behavioural bit-serial carry adder attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_sched;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0, req1;
   logic [WIDTH-1:0] a0, b0, a1, b1;
   logic             gnt0, gnt1, busy, done, done_id, cout;
   logic [WIDTH-1:0] sum;
   logic             sa_a, sa_b, sa_clr, sa_s;
   logic             carry = 1'b0;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   serial_add_sched #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
      .done_id(done_id), .sum(sum), .cout(cout),
      .sa_a(sa_a), .sa_b(sa_b), .sa_clr(sa_clr), .sa_s(sa_s)
   );

   always #5 clk = ~clk;

   // cycle counter, advanced on every active edge
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural serial carry adder: carry flop with async clear
   always @(posedge clk or posedge sa_clr) begin
      if (sa_clr) carry <= 1'b0;
      else        carry <= (sa_a & sa_b) | (carry & (sa_a ^ sa_b));
   end
   assign sa_s = sa_a ^ sa_b ^ carry;

   // grants must be exclusive and only while not busy
   always @(negedge clk) begin
      if (rst === 1'b0 && (gnt0 === 1'b1 || gnt1 === 1'b1)) begin
         checks++;
         if (gnt0 === 1'b1 && gnt1 === 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gnt_excl: gnt0=%b gnt1=%b busy=%b, required one grant with busy=0",
                     gnt0, gnt1, busy);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({busy, gnt0, gnt1, done, done_id, cout, sa_a, sa_b, sa_clr} !== 9'b0_0000_0001) begin
         errors++;
         $display("FAIL reset_outs: got %b required %b",
                  {busy, gnt0, gnt1, done, done_id, cout, sa_a, sa_b, sa_clr}, 9'b0_0000_0001);
      end
      checks++;
      if (sum !== 8'h00) begin
         errors++;
         $display("FAIL reset_sum: got %h required 00", sum);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_single0();
      int t;
      bit got;
      @(negedge clk);
      req0 = 1'b1; a0 = 8'h5A; b0 = 8'h3C;
      #1;
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL s0_grant: gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
      end
      t = cyc;
      @(negedge clk);
      req0 = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL s0_busy: got %b required 1", busy);
      end
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         #1;
         if (done === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL s0_done: no done within 20 cycles");
      end else if (cyc - t != 11) begin
         errors++;
         $display("FAIL s0_latency: got %0d required 11", cyc - t);
      end
      checks++;
      if ({done_id, cout, sum} !== {1'b0, 1'b0, 8'h96}) begin
         errors++;
         $display("FAIL s0_result: got id=%b cout=%b sum=%h required id=0 cout=0 sum=96",
                  done_id, cout, sum);
      end
   endtask

   task automatic test_single1();
      int low;
      bit got;
      @(negedge clk);
      req1 = 1'b1; a1 = 8'hFF; b1 = 8'h01;
      #1;
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
         errors++;
         $display("FAIL s1_grant: gnt0=%b gnt1=%b required 0 1", gnt0, gnt1);
      end
      low = 0;
      got = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         req1 = 1'b0;
         #1;
         if (sa_clr === 1'b0) low++;
         if (done === 1'b1) got = 1'b1;
      end
      checks++;
      if (low != 9) begin
         errors++;
         $display("FAIL s1_clr_low: got %0d cycles required 9", low);
      end
      checks++;
      if (!got || {done_id, cout, sum} !== {1'b1, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL s1_result: done_seen=%b id=%b cout=%b sum=%h required 1 1 1 00",
                  got, done_id, cout, sum);
      end
   endtask

   task automatic test_both_held();
      int   ng, nd;
      int   gc[4];
      logic gi[4];
      logic di[4];
      logic [8:0] dr[4];
      logic [8:0] exp_r;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
      req1 = 1'b1; a1 = 8'h80; b1 = 8'h80;
      ng = 0;
      nd = 0;
      for (int k = 0; k < 70 && nd < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if ((gnt0 === 1'b1 || gnt1 === 1'b1) && ng < 4) begin
            gi[ng] = gnt1; gc[ng] = cyc; ng++;
         end
         if (done === 1'b1 && nd < 4) begin
            di[nd] = done_id; dr[nd] = {cout, sum}; nd++;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      checks++;
      if (ng != 4 || nd != 4) begin
         errors++;
         $display("FAIL both_count: grants=%0d dones=%0d required 4 4", ng, nd);
      end else begin
         for (int i = 0; i < 4; i++) begin
            exp_r = ((i % 2) == 1) ? 9'h100 : 9'h046;
            checks++;
            if (gi[i] !== ((i % 2) == 1)) begin
               errors++;
               $display("FAIL both_order[%0d]: got gnt id %b required %0d", i, gi[i], i % 2);
            end
            checks++;
            if (di[i] !== ((i % 2) == 1) || dr[i] !== exp_r) begin
               errors++;
               $display("FAIL both_done[%0d]: got id=%b res=%h required id=%0d res=%h",
                        i, di[i], dr[i], i % 2, exp_r);
            end
            if (i > 0) begin
               checks++;
               if (gc[i] - gc[i-1] != 12) begin
                  errors++;
                  $display("FAIL both_spacing[%0d]: got %0d required 12", i, gc[i] - gc[i-1]);
               end
            end
         end
      end
   endtask

   task automatic test_sole_held();
      int   ng, nd;
      int   gc[3];
      logic gi[3];
      @(negedge clk);
      req0 = 1'b1; a0 = 8'h01; b0 = 8'h02;
      ng = 0;
      nd = 0;
      for (int k = 0; k < 60 && nd < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if ((gnt0 === 1'b1 || gnt1 === 1'b1) && ng < 3) begin
            gi[ng] = gnt1; gc[ng] = cyc; ng++;
         end
         if (done === 1'b1) nd++;
      end
      req0 = 1'b0;
      checks++;
      if (ng != 3 || nd != 3) begin
         errors++;
         $display("FAIL sole_count: grants=%0d dones=%0d required 3 3", ng, nd);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (gi[i] !== 1'b0) begin
               errors++;
               $display("FAIL sole_id[%0d]: got %b required 0", i, gi[i]);
            end
            if (i > 0) begin
               checks++;
               if (gc[i] - gc[i-1] != 12) begin
                  errors++;
                  $display("FAIL sole_spacing[%0d]: got %0d required 12", i, gc[i] - gc[i-1]);
               end
            end
         end
      end
      checks++;
      if (sum !== 8'h03 || cout !== 1'b0) begin
         errors++;
         $display("FAIL sole_result: got cout=%b sum=%h required 0 03", cout, sum);
      end
   endtask

   task automatic test_reset_mid();
      bit got;
      @(negedge clk);
      req1 = 1'b1; a1 = 8'hA5; b1 = 8'h11;
      @(negedge clk);
      req1 = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (sa_clr !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_in_add: sa_clr=%b busy=%b required 0 1", sa_clr, busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, gnt0, gnt1, done, done_id, cout, sa_a, sa_b, sa_clr} !== 9'b0_0000_0001
          || sum !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_outs: got %b sum=%h required %b sum=00",
                  {busy, gnt0, gnt1, done, done_id, cout, sa_a, sa_b, sa_clr}, sum, 9'b0_0000_0001);
      end
      @(negedge clk);
      rst = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         #1;
         if (done === 1'b1) got = 1'b1;
      end
      checks++;
      if (got || sum !== 8'h00 || cout !== 1'b0) begin
         errors++;
         $display("FAIL mid_abort: done_seen=%b sum=%h cout=%b required 0 00 0", got, sum, cout);
      end
      @(negedge clk);
      req1 = 1'b1; a1 = 8'hC8; b1 = 8'h64;
      #1;
      checks++;
      if (gnt1 !== 1'b1) begin
         errors++;
         $display("FAIL mid_regrant: gnt1=%b required 1", gnt1);
      end
      @(negedge clk);
      req1 = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         #1;
         if (done === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got || {done_id, cout, sum} !== {1'b1, 1'b1, 8'h2C}) begin
         errors++;
         $display("FAIL mid_after: done_seen=%b id=%b cout=%b sum=%h required 1 1 1 2C",
                  got, done_id, cout, sum);
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] ra, rb;
      logic [WIDTH:0]   e;
      logic             id;
      bit               got;
      for (int j = 0; j < 1000; j++) begin
         @(negedge clk);
         id = 1'($urandom_range(0, 1));
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         e  = {1'b0, ra} + {1'b0, rb};
         if (id) begin req1 = 1'b1; a1 = ra; b1 = rb; end
         else    begin req0 = 1'b1; a0 = ra; b0 = rb; end
         #1;
         checks++;
         if (gnt0 !== ~id || gnt1 !== id) begin
            errors++;
            $display("FAIL rand_grant[%0d]: gnt0=%b gnt1=%b required id %b", j, gnt0, gnt1, id);
         end
         @(negedge clk);
         req0 = 1'b0;
         req1 = 1'b0;
         got = 1'b0;
         for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) got = 1'b1;
         end
         checks++;
         if (!got || {done_id, cout, sum} !== {id, e}) begin
            errors++;
            $display("FAIL rand_result[%0d]: done_seen=%b got id=%b res=%h required id=%b res=%h (a=%h b=%h)",
                     j, got, done_id, {cout, sum}, id, e, ra, rb);
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      test_reset();
      test_single0();
      test_single1();
      test_both_held();
      test_sole_held();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
